// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Provides:
//   imem_addr_width_default_p : default word-address width of imem and PC
//   state_e                   : registered core state (IDLE/RUN/ERR)
//   instruction_s             : 16-bit instruction word layout
//   kNOP, kWAIT               : bubble filler and the WAIT instruction
//   is_wait()                 : opcode-only match against kWAIT (operand
//                               fields are don't-care for WAIT)
package fetch_stage_pkg;

  localparam int unsigned imem_addr_width_default_p = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs_imm;
  } instruction_s;

  localparam logic [5:0] kNOP_OP  = 6'b000000;
  localparam logic [5:0] kWAIT_OP = 6'b010000;

  localparam instruction_s kNOP  = '{opcode: kNOP_OP,  rd: 5'd0, rs_imm: 5'd0};
  localparam instruction_s kWAIT = '{opcode: kWAIT_OP, rd: 5'd0, rs_imm: 5'd0};

  // WAIT is identified by opcode alone; rd/rs_imm may hold anything.
  function automatic logic is_wait(input instruction_s instr);
    return instr.opcode == kWAIT.opcode;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority mux for the fetch stage.
// Ports:
//   net_write_idle : IDLE-qualified network PC write (highest priority)
//   net_pc         : PC value carried by the network packet
//   state          : registered core state
//   stall          : downstream stall
//   jump_now       : taken branch/jump from execute
//   jump_addr      : redirect target
//   wait_hold      : a valid WAIT sits in the fetch/decode register
//   pc             : current PC
//   next_pc        : PC to load on the next clock edge
module fetch_next_pc
  import fetch_stage_pkg::*;
#(
  parameter int imem_addr_width_p = imem_addr_width_default_p
) (
  input  logic                         net_write_idle,
  input  logic [imem_addr_width_p-1:0] net_pc,
  input  state_e                       state,
  input  logic                         stall,
  input  logic                         jump_now,
  input  logic [imem_addr_width_p-1:0] jump_addr,
  input  logic                         wait_hold,
  input  logic [imem_addr_width_p-1:0] pc,
  output logic [imem_addr_width_p-1:0] next_pc
);

  localparam logic [imem_addr_width_p-1:0] pc_step = {{(imem_addr_width_p-1){1'b0}}, 1'b1};

  // Sequential fetch wraps naturally at 2^width because the adder is
  // exactly the PC width.
  always_comb begin
    next_pc = pc + pc_step;
    if (net_write_idle) begin
      next_pc = net_pc;
    end else if (state != RUN) begin
      next_pc = pc;
    end else if (stall) begin
      next_pc = pc;
    end else if (jump_now) begin
      next_pc = jump_addr;
    end else if (wait_hold) begin
      // PC already points one past the WAIT; park it there.
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the imem read address,
// and registers the fetched word into the fetch/decode pipeline register.
// Ports:
//   clk, reset                : core clock, async active-high reset
//   state_i                   : registered core state
//   net_PC_write_cmd_i        : network packet requests a PC write
//   net_pc_i                  : PC value from the network packet
//   stall_i                   : downstream stall
//   jump_now_i, jump_addr_i   : execute-stage redirect
//   imem_data_i               : combinational imem read data for imem_addr_o
//   imem_addr_o               : current PC
//   net_PC_write_cmd_IDLE_o   : network PC write qualified by IDLE
//   instruction_o, pc_o,
//   valid_o                   : fetch/decode register contents
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int imem_addr_width_p = imem_addr_width_default_p
) (
  input  logic                         clk,
  input  logic                         reset,
  input  state_e                       state_i,
  input  logic                         net_PC_write_cmd_i,
  input  logic [imem_addr_width_p-1:0] net_pc_i,
  input  logic                         stall_i,
  input  logic                         jump_now_i,
  input  logic [imem_addr_width_p-1:0] jump_addr_i,
  input  instruction_s                 imem_data_i,
  output logic [imem_addr_width_p-1:0] imem_addr_o,
  output logic                         net_PC_write_cmd_IDLE_o,
  output instruction_s                 instruction_o,
  output logic [imem_addr_width_p-1:0] pc_o,
  output logic                         valid_o
);

  logic [imem_addr_width_p-1:0] pc_r;
  logic [imem_addr_width_p-1:0] pc_next;

  instruction_s                 instr_r;
  instruction_s                 instr_next;
  logic [imem_addr_width_p-1:0] fd_pc_r;
  logic [imem_addr_width_p-1:0] fd_pc_next;
  logic                         valid_r;
  logic                         valid_next;

  logic                         wait_hold;

  assign net_PC_write_cmd_IDLE_o = net_PC_write_cmd_i & (state_i == IDLE);
  assign wait_hold               = valid_r & is_wait(instr_r);

  fetch_next_pc #(
    .imem_addr_width_p(imem_addr_width_p)
  ) next_pc_mux (
    .net_write_idle(net_PC_write_cmd_IDLE_o),
    .net_pc        (net_pc_i),
    .state         (state_i),
    .stall         (stall_i),
    .jump_now      (jump_now_i),
    .jump_addr     (jump_addr_i),
    .wait_hold     (wait_hold),
    .pc            (pc_r),
    .next_pc       (pc_next)
  );

  // Fetch/decode register next value. A bubble keeps the old pc_o so the
  // decode stage always sees the PC of the last real fetch.
  always_comb begin
    instr_next = instr_r;
    fd_pc_next = fd_pc_r;
    valid_next = valid_r;
    if (stall_i && (state_i == RUN)) begin
      instr_next = instr_r;
    end else if ((state_i != RUN) || jump_now_i || wait_hold) begin
      instr_next = kNOP;
      valid_next = 1'b0;
    end else begin
      instr_next = imem_data_i;
      fd_pc_next = pc_r;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= '0;
      instr_r <= kNOP;
      fd_pc_r <= '0;
      valid_r <= 1'b0;
    end else begin
      pc_r    <= pc_next;
      instr_r <= instr_next;
      fd_pc_r <= fd_pc_next;
      valid_r <= valid_next;
    end
  end

  assign imem_addr_o   = pc_r;
  assign instruction_o = instr_r;
  assign pc_o          = fd_pc_r;
  assign valid_o       = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Each cycle the stimulus process
// drives inputs just after the rising edge and pushes the outputs expected
// during that cycle; the monitor pops and compares on the falling edge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int W = 10;

  logic         clk;
  logic         reset;
  state_e       stateIn;
  logic         netCmd;
  logic [W-1:0] netPc;
  logic         stall;
  logic         jumpNow;
  logic [W-1:0] jumpAddr;
  instruction_s imemData;
  logic [W-1:0] imemAddr;
  logic         netIdle;
  instruction_s instrOut;
  logic [W-1:0] pcOut;
  logic         validOut;

  typedef struct {
    string        name;
    logic [W-1:0] addr;
    logic         valid;
    instruction_s instr;
    logic [W-1:0] pc;
    logic         netIdle;
  } expRec_t;

  expRec_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  fetch_stage #(.imem_addr_width_p(W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .state_i                (stateIn),
    .net_PC_write_cmd_i     (netCmd),
    .net_pc_i               (netPc),
    .stall_i                (stall),
    .jump_now_i             (jumpNow),
    .jump_addr_i            (jumpAddr),
    .imem_data_i            (imemData),
    .imem_addr_o            (imemAddr),
    .net_PC_write_cmd_IDLE_o(netIdle),
    .instruction_o          (instrOut),
    .pc_o                   (pcOut),
    .valid_o                (validOut)
  );

  // Instruction memory model: every word encodes its own address, except
  // a WAIT planted at 0x020.
  function automatic instruction_s imemWord(input logic [W-1:0] a);
    if (a == 10'h020) return instruction_s'({kWAIT_OP, a});
    return instruction_s'({6'b000001, a});
  endfunction

  always_comb imemData = imemWord(imemAddr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input state_e st, input logic nc,
                               input logic [W-1:0] np, input logic stl,
                               input logic j, input logic [W-1:0] ja);
    @(posedge clk);
    #1;
    reset    = rst;
    stateIn  = st;
    netCmd   = nc;
    netPc    = np;
    stall    = stl;
    jumpNow  = j;
    jumpAddr = ja;
  endtask

  task automatic pushExpected(input string name, input logic [W-1:0] addr, input logic v,
                              input instruction_s ins, input logic [W-1:0] pc, input logic ni);
    expRec_t r;
    r.name    = name;
    r.addr    = addr;
    r.valid   = v;
    r.instr   = ins;
    r.pc      = pc;
    r.netIdle = ni;
    expQ.push_back(r);
  endtask

  // Monitor: compares one expected record per cycle, mid-cycle.
  initial begin
    expRec_t rec;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        rec = expQ.pop_front();
        checkOutput({rec.name, ".imem_addr"}, {6'd0, imemAddr}, {6'd0, rec.addr});
        checkOutput({rec.name, ".valid"}, {15'd0, validOut}, {15'd0, rec.valid});
        checkOutput({rec.name, ".instr"}, instrOut, rec.instr);
        checkOutput({rec.name, ".pc_o"}, {6'd0, pcOut}, {6'd0, rec.pc});
        checkOutput({rec.name, ".net_idle"}, {15'd0, netIdle}, {15'd0, rec.netIdle});
      end
    end
  end

  initial begin
    reset    = 1'b0;
    stateIn  = IDLE;
    netCmd   = 1'b1;
    netPc    = 10'h010;
    stall    = 1'b0;
    jumpNow  = 1'b0;
    jumpAddr = '0;
    #2 reset = 1'b1;

    applyStimulus(1, IDLE, 1, 10'h010, 0, 0, 10'h000); pushExpected("reset",        10'h000, 0, kNOP,               10'h000, 1);
    applyStimulus(0, IDLE, 1, 10'h010, 0, 0, 10'h000); pushExpected("netWrite",     10'h000, 0, kNOP,               10'h000, 1);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("runStart",     10'h010, 0, kNOP,               10'h000, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("fetch010",     10'h011, 1, imemWord(10'h010),  10'h010, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("fetch011",     10'h012, 1, imemWord(10'h011),  10'h011, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("fetch012",     10'h013, 1, imemWord(10'h012),  10'h012, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 1, 10'h100); pushExpected("jumpIssue",    10'h014, 1, imemWord(10'h013),  10'h013, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("jumpBubble",   10'h100, 0, kNOP,               10'h013, 0);
    applyStimulus(0, RUN,  0, 10'h000, 1, 1, 10'h200); pushExpected("jumpTarget",   10'h101, 1, imemWord(10'h100),  10'h100, 0);
    applyStimulus(0, RUN,  0, 10'h000, 1, 1, 10'h200); pushExpected("stall1",       10'h101, 1, imemWord(10'h100),  10'h100, 0);
    applyStimulus(0, RUN,  0, 10'h000, 1, 1, 10'h200); pushExpected("stall2",       10'h101, 1, imemWord(10'h100),  10'h100, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 1, 10'h200); pushExpected("stall3",       10'h101, 1, imemWord(10'h100),  10'h100, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("redirBubble",  10'h200, 0, kNOP,               10'h100, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 1, 10'h01F); pushExpected("redirTarget",  10'h201, 1, imemWord(10'h200),  10'h200, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("toWaitBubble", 10'h01F, 0, kNOP,               10'h200, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("fetch01F",     10'h020, 1, imemWord(10'h01F),  10'h01F, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("waitSeen",     10'h021, 1, imemWord(10'h020),  10'h020, 0);
    applyStimulus(0, IDLE, 0, 10'h000, 0, 0, 10'h000); pushExpected("waitBubble",   10'h021, 0, kNOP,               10'h020, 0);
    applyStimulus(0, IDLE, 1, 10'h040, 0, 0, 10'h000); pushExpected("idleWrite",    10'h021, 0, kNOP,               10'h020, 1);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("resume040",    10'h040, 0, kNOP,               10'h020, 0);
    applyStimulus(0, RUN,  1, 10'h155, 0, 0, 10'h000); pushExpected("runNetIgnore", 10'h041, 1, imemWord(10'h040),  10'h040, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 1, 10'h3FE); pushExpected("fetch041",     10'h042, 1, imemWord(10'h041),  10'h041, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("wrapBubble",   10'h3FE, 0, kNOP,               10'h041, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("pcMax",        10'h3FF, 1, imemWord(10'h3FE),  10'h3FE, 0);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("pcWrap",       10'h000, 1, imemWord(10'h3FF),  10'h3FF, 0);
    applyStimulus(1, RUN,  0, 10'h000, 1, 1, 10'h123); pushExpected("asyncReset",   10'h000, 0, kNOP,               10'h000, 0);
    applyStimulus(0, IDLE, 1, 10'h080, 0, 0, 10'h000); pushExpected("afterReset",   10'h000, 0, kNOP,               10'h000, 1);
    applyStimulus(0, RUN,  0, 10'h000, 0, 0, 10'h000); pushExpected("run080",       10'h080, 0, kNOP,               10'h000, 0);
    applyStimulus(0, ERR,  0, 10'h000, 0, 0, 10'h000); pushExpected("fetch080",     10'h081, 1, imemWord(10'h080),  10'h080, 0);
    applyStimulus(0, ERR,  1, 10'h155, 0, 1, 10'h123); pushExpected("errBubble",    10'h081, 0, kNOP,               10'h080, 0);
    applyStimulus(0, ERR,  0, 10'h000, 0, 0, 10'h000); pushExpected("errFrozen",    10'h081, 0, kNOP,               10'h080, 0);

    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d records left, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
